rob_ctrl: RTL and testbench

Reorder-buffer controller for the out-of-order RV32I core. It allocates entries in program order from dispatch and returns a tag per entry. It captures results broadcast on the common data bus (CDB) and retires completed entries in order to the register-file commit port. It sits between dispatch/rename, the CDB, and architectural-state update, and owns the head/tail pointers and the per-entry valid/done state.

---
 rtl/rob_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rob_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer controller for the out-of-order RV32I core.
// Allocates entries in program order, captures CDB results, and retires the
// head entry in order to the register-file commit port.
// Optional feature macro: ROB_COMMIT_BYPASS_EN. When it is defined, a CDB hit
// on the not-done head entry is committed in the same cycle.
module rob_ctrl #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    // Dispatch / allocate
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [6:0]       alloc_op,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_done,
    output logic [TAG_W-1:0] alloc_tag,
    // Common data bus
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    // Commit
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [6:0]       commit_op,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] commit_tag,
    // Control / status
    input  logic             flush,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [TAG_W:0] PtrOne = {{TAG_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit above the index.
    logic [TAG_W:0]     head_q, head_d;
    logic [TAG_W:0]     tail_q, tail_d;
    logic [TAG_W-1:0]   head_idx;
    logic [TAG_W-1:0]   tail_idx;

    // Per-entry state.
    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [6:0]           op_q    [ROB_DEPTH];
    logic [4:0]           rd_q    [ROB_DEPTH];
    logic [31:0]          value_q [ROB_DEPTH];

    logic alloc_fire;
    logic cdb_hit;
    logic bypass_hit;
    logic commit_fire;
    logic head_done;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];

    // Occupancy status derived from the wrap-bit pointers.
    always_comb begin
        empty = (head_q == tail_q);
        full  = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
        count = tail_q - head_q;
    end

    // Allocation handshake; a same-cycle commit does not free a slot here.
    always_comb begin
        alloc_ready = !full;
        alloc_tag   = tail_idx;
        alloc_fire  = alloc_valid && alloc_ready;
    end

    // CDB capture: only live, still-pending entries, never the slot being allocated.
    always_comb begin
        cdb_hit = cdb_valid && valid_q[cdb_tag] && !done_q[cdb_tag]
                  && !(alloc_fire && (cdb_tag == tail_idx));
    end

`ifdef ROB_COMMIT_BYPASS_EN
    // Head bypass: a CDB hit on the pending head is presented for commit at once.
    always_comb begin
        bypass_hit = cdb_valid && !empty && (cdb_tag == head_idx)
                     && valid_q[head_idx] && !done_q[head_idx];
    end
`else
    // No bypass: commit sees only registered done/value.
    always_comb begin
        bypass_hit = 1'b0;
    end
`endif

    // Commit port is driven straight from the head entry; flush masks valid.
    always_comb begin
        head_done    = done_q[head_idx];
        commit_valid = !flush && !empty && (head_done || bypass_hit);
        commit_op    = op_q[head_idx];
        commit_rd    = rd_q[head_idx];
        commit_value = bypass_hit ? cdb_value : value_q[head_idx];
        commit_tag   = head_idx;
        commit_fire  = commit_valid && commit_ready;
    end

    // Pointer next state; flush returns both pointers to zero.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + PtrOne;
            end
            if (commit_fire) begin
                head_d = head_q + PtrOne;
            end
        end
    end

    // Valid/done next state. Commit clears last so a bypassed, accepted head
    // does not leave a stale done bit behind.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (alloc_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = alloc_done;
            end
            if (cdb_hit) begin
                done_d[cdb_tag] = 1'b1;
            end
            if (commit_fire) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
            end
        end
    end

    // Pointer and status-bit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Entry payload storage; alloc and CDB never target the same slot in a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                op_q[i]    <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (!flush) begin
            if (alloc_fire) begin
                op_q[tail_idx]    <= alloc_op;
                rd_q[tail_idx]    <= alloc_rd;
                value_q[tail_idx] <= '0;
            end
            if (cdb_hit) begin
                value_q[cdb_tag] <= cdb_value;
            end
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl: a program-order queue models the ROB, the
// stimulus process updates it at each clock edge, and a negedge monitor
// compares every status/commit output and retires entries from the queue.
module tb_rob_ctrl;

    localparam int DEPTH = 16;
    localparam int TW    = 4;
`ifdef ROB_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid, alloc_ready, alloc_done;
    logic [6:0]    alloc_op;
    logic [4:0]    alloc_rd;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_value;
    logic          commit_valid, commit_ready;
    logic [6:0]    commit_op;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;
    logic [TW-1:0] commit_tag;
    logic          flush;
    logic [TW:0]   count;
    logic          full, empty;

    rob_ctrl #(.ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_rd(alloc_rd), .alloc_done(alloc_done), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_op(commit_op),
        .commit_rd(commit_rd), .commit_value(commit_value), .commit_tag(commit_tag),
        .flush(flush), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] value;
        bit          done;
    } ent_t;

    ent_t        q[$];
    int          next_tag = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          in_reset = 1'b1;
    bit          acc_alloc = 1'b0;
    bit          m_cv;
    logic [31:0] m_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs against the model, retire accepted commits.
    always @(negedge clk) begin
        if (!in_reset) begin
            m_cv  = 1'b0;
            m_val = '0;
            if (!flush && q.size() > 0) begin
                if (q[0].done) begin
                    m_cv  = 1'b1;
                    m_val = q[0].value;
                end else if (BYP && cdb_valid && int'(cdb_tag) == q[0].tag) begin
                    m_cv  = 1'b1;
                    m_val = cdb_value;
                end
            end
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
            if (q.size() < DEPTH) chk("alloc_tag", 32'(alloc_tag), 32'(next_tag));
            chk("commit_valid", 32'(commit_valid), 32'(m_cv));
            if (m_cv) begin
                chk("commit_tag", 32'(commit_tag), 32'(q[0].tag));
                chk("commit_op", 32'(commit_op), 32'(q[0].op));
                chk("commit_rd", 32'(commit_rd), 32'(q[0].rd));
                chk("commit_value", commit_value, m_val);
            end
            // Acceptance is judged on occupancy before this cycle's commit.
            acc_alloc = alloc_valid && (q.size() < DEPTH);
            if (m_cv && commit_ready) void'(q.pop_front());
        end
    end

    // Advance one clock and apply flush / CDB / alloc to the model.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        if (!in_reset) begin
            if (flush) begin
                q.delete();
                next_tag = 0;
            end else begin
                if (cdb_valid) begin
                    foreach (q[i]) begin
                        if (q[i].tag == int'(cdb_tag) && !q[i].done) begin
                            q[i].done  = 1'b1;
                            q[i].value = cdb_value;
                        end
                    end
                end
                if (acc_alloc) begin
                    e.tag   = next_tag;
                    e.op    = alloc_op;
                    e.rd    = alloc_rd;
                    e.value = '0;
                    e.done  = alloc_done;
                    q.push_back(e);
                    next_tag = (next_tag + 1) % DEPTH;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_op = 0; alloc_rd = 0; alloc_done = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0; flush = 0;
    endtask

    task automatic alloc1(input logic [4:0] rd, input logic dn);
        alloc_valid = 1; alloc_op = 7'($urandom); alloc_rd = rd; alloc_done = dn;
        tick();
        alloc_valid = 0;
    endtask

    task automatic drain();
        commit_ready = 1;
        for (int i = 0; i < 64 && q.size() > 0; i++) tick();
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    int t0;

    initial begin
        idle_inputs();
        commit_ready = 0;
        #3;
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_commit_op", 32'(commit_op), 32'd0);
        chk("rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("rst_commit_value", commit_value, 32'd0);
        chk("rst_commit_tag", 32'(commit_tag), 32'd0);
        @(posedge clk); #1;
        rst_n = 1; in_reset = 0;
        repeat (3) tick();

        // Fill 16, attempt one more while full, then complete in reverse.
        commit_ready = 1;
        for (int k = 1; k <= DEPTH; k++) alloc1(5'(k), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(alloc_ready), 32'd0);
        alloc1(5'd31, 1'b0);
        for (int t = DEPTH - 1; t >= 0; t--) begin
            cdb_valid = 1; cdb_tag = TW'(t); cdb_value = 32'(t * 3);
            tick();
        end
        cdb_valid = 0;
        drain();

        // Out-of-order completion.
        t0 = next_tag;
        alloc1(5'd3, 1'b0);
        alloc1(5'd4, 1'b0);
        cdb_valid = 1; cdb_tag = TW'(t0 + 1); cdb_value = 32'h1111;
        tick();
        cdb_valid = 0;
        tick();
        chk("ooo_wait", 32'(commit_valid), 32'd0);
        cdb_valid = 1; cdb_tag = TW'(t0); cdb_value = 32'h2222;
        tick();
        cdb_valid = 0;
        chk("ooo_head", 32'(commit_valid), 32'd1);
        drain();

        // Back-pressure hold, then sustained alloc+commit across the wrap.
        commit_ready = 0;
        alloc1(5'd7, 1'b1);
        repeat (5) tick();
        commit_ready = 1;
        for (int i = 0; i < 40; i++) begin
            alloc_valid = 1; alloc_op = 7'($urandom); alloc_rd = 5'($urandom);
            alloc_done = 1;
            tick();
            chk("steady_count", 32'(count), 32'd1);
        end
        alloc_valid = 0;
        drain();

        // Flush with everything else asserted in the same cycle.
        flush = 1; tick(); flush = 0;
        commit_ready = 0;
        alloc1(5'd1, 1'b1);
        for (int k = 2; k <= 6; k++) alloc1(5'(k), 1'b0);
        flush = 1; alloc_valid = 1; alloc_done = 1; alloc_rd = 5'd9;
        cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'h3333; commit_ready = 1;
        #1;
        chk("flush_no_commit", 32'(commit_valid), 32'd0);
        tick();
        idle_inputs();
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ready", 32'(alloc_ready), 32'd1);
        chk("flush_tag", 32'(alloc_tag), 32'd0);
        cdb_valid = 1; cdb_tag = 4'd3; cdb_value = 32'h4444;
        tick();
        cdb_valid = 0;
        for (int k = 0; k < 4; k++) alloc1(5'(k + 1), 1'b0);
        repeat (2) tick();
        chk("stale_cdb", 32'(commit_valid), 32'd0);
        for (int t = 0; t < 4; t++) begin
            cdb_valid = 1; cdb_tag = TW'(t); cdb_value = 32'(t + 100);
            tick();
        end
        cdb_valid = 0;
        drain();

        // Head bypass (or one-cycle latency without it).
        t0 = next_tag;
        alloc1(5'd5, 1'b0);
        cdb_valid = 1; cdb_tag = TW'(t0); cdb_value = 32'hDEADBEEF;
        #1;
        chk("byp_same_valid", 32'(commit_valid), 32'(BYP));
        if (BYP) chk("byp_same_value", commit_value, 32'hDEADBEEF);
        tick();
        cdb_valid = 0;
        chk("byp_next_valid", 32'(commit_valid), 32'(!BYP));
        if (!BYP) chk("byp_next_value", commit_value, 32'hDEADBEEF);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            alloc_valid  = ($urandom_range(0, 9) < 6);
            alloc_op     = 7'($urandom);
            alloc_rd     = 5'($urandom);
            alloc_done   = ($urandom_range(0, 3) == 0);
            cdb_valid    = $urandom_range(0, 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_tag = TW'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                cdb_tag = TW'($urandom_range(0, DEPTH - 1));
            cdb_value    = $urandom;
            commit_ready = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle_inputs();
        flush = 1; tick(); flush = 0;
        tick();

        // Asynchronous reset with entries in flight.
        commit_ready = 0;
        alloc1(5'd1, 1'b1);
        alloc1(5'd2, 1'b1);
        alloc1(5'd3, 1'b0);
        in_reset = 1; rst_n = 0;
        #1;
        chk("areset_commit_valid", 32'(commit_valid), 32'd0);
        chk("areset_empty", 32'(empty), 32'd1);
        chk("areset_count", 32'(count), 32'd0);
        chk("areset_ready", 32'(alloc_ready), 32'd1);
        chk("areset_value", commit_value, 32'd0);
        q.delete(); next_tag = 0;
        @(posedge clk); #1;
        rst_n = 1; in_reset = 0;
        commit_ready = 1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
